// File: rtl/cpu_pkg.sv
// Shared constants for the CPU control path: opcodes, ALU codes, sequencer states and fault codes.
package cpu_pkg;

   localparam logic [4:0] OP_LD   = 5'h00;
   localparam logic [4:0] OP_LDI  = 5'h01;
   localparam logic [4:0] OP_ST   = 5'h02;
   localparam logic [4:0] OP_ADD  = 5'h03;
   localparam logic [4:0] OP_SUB  = 5'h04;
   localparam logic [4:0] OP_AND  = 5'h05;
   localparam logic [4:0] OP_OR   = 5'h06;
   localparam logic [4:0] OP_ADDI = 5'h0C;
   localparam logic [4:0] OP_NOP  = 5'h19;
   localparam logic [4:0] OP_HALT = 5'h1A;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU, CLS_ADDI, CLS_LDI, CLS_LD, CLS_ST, CLS_NOP, CLS_HALT, CLS_BAD
   } op_class_e;

   function automatic op_class_e classify(input logic [4:0] op);
      op_class_e cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_ALU;
         OP_ADDI:                       cls = CLS_ADDI;
         OP_LDI:                        cls = CLS_LDI;
         OP_LD:                         cls = CLS_LD;
         OP_ST:                         cls = CLS_ST;
         OP_NOP:                        cls = CLS_NOP;
         OP_HALT:                       cls = CLS_HALT;
         default:                       cls = CLS_BAD;
      endcase
      return cls;
   endfunction

   function automatic logic [3:0] alu_code(input logic [4:0] op);
      logic [3:0] code;
      case (op)
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired_o flags the last allowed wait cycle.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

   logic [W-1:0] count_q, count_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Clear wins so the count restarts on every state change, including the timeout exit.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + W'(1);
      end
   end

   assign expired_o = (count_q == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM with memory handshake and fault capture.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       run,
   input  logic [4:0] ir_opcode,
   input  logic       mem_ready,
   output logic       pc_out,
   output logic       mar_in,
   output logic       inc_pc,
   output logic       pc_in,
   output logic       z_in,
   output logic       zlow_out,
   output logic       y_in,
   output logic       ir_in,
   output logic       mdr_out,
   output logic       c_out,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mdr_in,
   output logic       gra,
   output logic       grb,
   output logic       grc,
   output logic       rin,
   output logic       rout,
   output logic       baout,
   output logic [3:0] alu_op,
   output logic       halted,
   output logic [1:0] fault
);

   state_e     state_q, state_d;
   logic [1:0] fault_q, fault_d;
   op_class_e  op_cls;
   state_e     done_state;
   logic       in_wait;
   logic       hold;
   logic       wait_expired;
   logic       timer_clear;

   assign op_cls     = classify(ir_opcode);
   assign done_state = run ? ST_T0 : ST_IDLE;
   assign in_wait    = (state_q == ST_T1)
                     | ((state_q == ST_T6) && (op_cls == CLS_LD))
                     | ((state_q == ST_T7) && (op_cls == CLS_ST));
   assign hold        = in_wait & ~mem_ready;
   assign timer_clear = (state_d != state_q);

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear_i   (timer_clear),
      .enable_i  (hold),
      .expired_o (wait_expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         fault_q <= FAULT_NONE;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: if (run) state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1: begin
            if (mem_ready) begin
               state_d = ST_T2;
            end else if (wait_expired) begin
               state_d = ST_HALT;
               fault_d = FAULT_TIMEOUT;
            end
         end
         ST_T2: begin
            case (op_cls)
               CLS_NOP:  state_d = done_state;
               CLS_HALT: state_d = ST_HALT;
               CLS_BAD: begin
                  state_d = ST_HALT;
                  fault_d = FAULT_ILLEGAL;
               end
               default:  state_d = ST_T3;
            endcase
         end
         ST_T3: state_d = ST_T4;
         ST_T4: state_d = ST_T5;
         ST_T5: state_d = (op_cls == CLS_LD || op_cls == CLS_ST) ? ST_T6 : done_state;
         ST_T6: begin
            if (op_cls == CLS_ST || mem_ready) begin
               state_d = ST_T7;
            end else if (wait_expired) begin
               state_d = ST_HALT;
               fault_d = FAULT_TIMEOUT;
            end
         end
         ST_T7: begin
            if (op_cls == CLS_LD || mem_ready) begin
               state_d = done_state;
            end else if (wait_expired) begin
               state_d = ST_HALT;
               fault_d = FAULT_TIMEOUT;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_out    = 1'b0;
      mar_in    = 1'b0;
      inc_pc    = 1'b0;
      pc_in     = 1'b0;
      z_in      = 1'b0;
      zlow_out  = 1'b0;
      y_in      = 1'b0;
      ir_in     = 1'b0;
      mdr_out   = 1'b0;
      c_out     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mdr_in    = 1'b0;
      gra       = 1'b0;
      grb       = 1'b0;
      grc       = 1'b0;
      rin       = 1'b0;
      rout      = 1'b0;
      baout     = 1'b0;
      alu_op    = ALU_ADD;
      halted    = 1'b0;
      case (state_q)
         ST_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         ST_T1: begin
            zlow_out = 1'b1;
            pc_in    = 1'b1;
            mem_read = 1'b1;
         end
         ST_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         // Address-forming opcodes take the base through baout so R0 reads as zero.
         ST_T3: begin
            grb  = 1'b1;
            y_in = 1'b1;
            if (op_cls == CLS_LD || op_cls == CLS_ST || op_cls == CLS_LDI) begin
               baout = 1'b1;
            end else begin
               rout = 1'b1;
            end
         end
         ST_T4: begin
            z_in = 1'b1;
            if (op_cls == CLS_ALU) begin
               grc    = 1'b1;
               rout   = 1'b1;
               alu_op = alu_code(ir_opcode);
            end else begin
               c_out = 1'b1;
            end
         end
         ST_T5: begin
            zlow_out = 1'b1;
            if (op_cls == CLS_LD || op_cls == CLS_ST) begin
               mar_in = 1'b1;
            end else begin
               gra = 1'b1;
               rin = 1'b1;
            end
         end
         ST_T6: begin
            if (op_cls == CLS_ST) begin
               gra    = 1'b1;
               rout   = 1'b1;
               mdr_in = 1'b1;
            end else begin
               mem_read = 1'b1;
            end
         end
         ST_T7: begin
            if (op_cls == CLS_ST) begin
               mem_write = 1'b1;
            end else begin
               mdr_out = 1'b1;
               gra     = 1'b1;
               rin     = 1'b1;
            end
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
      mdr_in = mdr_in | (mem_read & mem_ready);
   end

   assign fault = fault_q;

endmodule
